// File: rtl/rr_port_arbiter_pkg.sv
// rtl/rr_port_arbiter_pkg.sv - shared state encoding and width helper for the port arbiter
package rr_port_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Smallest r with 2**r >= v; used to size index and counter fields.
   function automatic int arb_clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_port_arbiter_if.sv
// rtl/rr_port_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface rr_port_arbiter_if
   import rr_port_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = arb_clog2(N_REQ)
) ();

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;
   logic             timeout;

   modport master (
      output req, done,
      input  grant, grant_idx, grant_valid, timeout
   );

   modport slave (
      input  req, done,
      output grant, grant_idx, grant_valid, timeout
   );

endinterface

// File: rtl/rr_port_arbiter_pick.sv
// rtl/rr_port_arbiter_pick.sv - rotating-priority winner scan starting at ptr
module rr_pick
   import rr_port_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = arb_clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] win_idx,
   output logic             win_valid
);

   // Index reached k steps after ptr, wrapping at N_REQ rather than 2**IDX_W.
   function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] p, input int k);
      int i;
      i = int'(p) + k;
      if (i >= N_REQ) i = i - N_REQ;
      return IDX_W'(i);
   endfunction

   // Scan from farthest to nearest so the request closest to ptr is the one left standing.
   always_comb begin
      win_idx   = '0;
      win_valid = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[rot_idx(ptr, k)]) begin
            win_idx   = rot_idx(ptr, k);
            win_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_port_arbiter.sv
// rtl/rr_port_arbiter.sv - round-robin arbiter with done/hold-timeout release for one shared port
module rr_port_arbiter
   import rr_port_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int IDX_W    = arb_clog2(N_REQ),
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = arb_clog2(MAX_HOLD + 1)
) (
   input logic              clk,
   input logic              rst,
   rr_port_arbiter_if.slave bus
);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   logic [IDX_W-1:0] win_idx;
   logic             win_valid;
   logic [IDX_W-1:0] ptr_after_owner;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req       (bus.req),
      .ptr       (ptr_q),
      .win_idx   (win_idx),
      .win_valid (win_valid)
   );

   // Priority moves to the requester after the releasing owner, wrapping at N_REQ.
   assign ptr_after_owner = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

   // Next-state logic: grant from IDLE, hold or release from BUSY; release always lands in IDLE.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      idx_d     = idx_q;
      grant_d   = grant_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_valid) begin
               state_d = ST_BUSY;
               idx_d   = win_idx;
               grant_d = N_REQ'(1) << win_idx;
               valid_d = 1'b1;
               hold_d  = '0;
            end
         end
         ST_BUSY: begin
            if (bus.done || (hold_q == CNT_W'(MAX_HOLD - 1))) begin
               state_d   = ST_IDLE;
               idx_d     = '0;
               grant_d   = '0;
               valid_d   = 1'b0;
               hold_d    = '0;
               ptr_d     = ptr_after_owner;
               timeout_d = ~bus.done;
            end else begin
               hold_d = hold_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            grant_d = '0;
            valid_d = 1'b0;
            hold_d  = '0;
         end
      endcase
   end

   // State and registered outputs; synchronous reset clears everything, even mid-grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         hold_q    <= '0;
         idx_q     <= '0;
         grant_q   <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         idx_q     <= idx_d;
         grant_q   <= grant_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = idx_q;
   assign bus.grant_valid = valid_q;
   assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb/tb_rr_port_arbiter.sv - self-checking bench for rr_port_arbiter (N_REQ=4 and N_REQ=3 instances)
module tb_rr_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   rr_port_arbiter_if #(.N_REQ(4)) ifc4 ();
   rr_port_arbiter_if #(.N_REQ(3)) ifc3 ();

   rr_port_arbiter #(.N_REQ(4), .MAX_HOLD(16)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (ifc4.slave)
   );

   rr_port_arbiter #(.N_REQ(3), .MAX_HOLD(5)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (ifc3.slave)
   );

   always #5 clk = ~clk;

   // Reference model, one entry per instance: 0 -> N=4/hold 16, 1 -> N=3/hold 5.
   int nreq  [2] = '{4, 3};
   int mhold [2] = '{16, 5};
   bit m_busy[2];
   int m_owner[2];
   int m_age[2];
   int m_ptr[2];
   bit m_to[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of the arbitration rules: owner keeps the port for at most mhold cycles.
   task automatic model_step(input int m, input bit r, input int reqv, input bit d);
      bit found;
      if (r) begin
         m_busy[m] = 0; m_ptr[m] = 0; m_to[m] = 0; m_owner[m] = 0; m_age[m] = 0;
      end else if (!m_busy[m]) begin
         m_to[m] = 0;
         found = 0;
         for (int k = 0; k < nreq[m]; k++) begin
            int c;
            c = (m_ptr[m] + k) % nreq[m];
            if (!found && ((reqv >> c) & 1) == 1) begin
               found = 1;
               m_busy[m] = 1;
               m_owner[m] = c;
               m_age[m] = 1;
            end
         end
      end else if (d) begin
         m_busy[m] = 0; m_to[m] = 0; m_ptr[m] = (m_owner[m] + 1) % nreq[m];
      end else if (m_age[m] == mhold[m]) begin
         m_busy[m] = 0; m_to[m] = 1; m_ptr[m] = (m_owner[m] + 1) % nreq[m];
      end else begin
         m_age[m]++;
         m_to[m] = 0;
      end
   endtask

   task automatic check_model();
      chk("d4_grant",   32'(ifc4.grant),       m_busy[0] ? (32'd1 << m_owner[0]) : 32'd0);
      chk("d4_idx",     32'(ifc4.grant_idx),   m_busy[0] ? 32'(m_owner[0]) : 32'd0);
      chk("d4_valid",   32'(ifc4.grant_valid), 32'(m_busy[0]));
      chk("d4_timeout", 32'(ifc4.timeout),     32'(m_to[0]));
      chk("d3_grant",   32'(ifc3.grant),       m_busy[1] ? (32'd1 << m_owner[1]) : 32'd0);
      chk("d3_idx",     32'(ifc3.grant_idx),   m_busy[1] ? 32'(m_owner[1]) : 32'd0);
      chk("d3_valid",   32'(ifc3.grant_valid), 32'(m_busy[1]));
      chk("d3_timeout", 32'(ifc3.timeout),     32'(m_to[1]));
   endtask

   // Advance one clock, step the model with the inputs the DUT sampled, then compare.
   task automatic tick();
      @(posedge clk);
      model_step(0, rst, int'(ifc4.req), ifc4.done);
      model_step(1, rst, int'(ifc3.req), ifc3.done);
      #1;
      check_model();
   endtask

   initial begin
      ifc4.req = '0; ifc4.done = 1'b0;
      ifc3.req = '0; ifc3.done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 0; m_owner[i] = 0; m_age[i] = 0; m_ptr[i] = 0; m_to[i] = 0;
      end

      // Reset state
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("rst_grant", 32'(ifc4.grant), 32'd0);
      chk("rst_valid", 32'(ifc4.grant_valid), 32'd0);
      chk("rst_timeout", 32'(ifc4.timeout), 32'd0);

      // Single request, then done; ptr must move to 3
      ifc4.req = 4'b0100;
      tick();
      chk("t1_grant", 32'(ifc4.grant), 32'h4);
      chk("t1_idx", 32'(ifc4.grant_idx), 32'd2);
      chk("t1_valid", 32'(ifc4.grant_valid), 32'd1);
      ifc4.req = '0; ifc4.done = 1'b1;
      tick();
      chk("t1_release", 32'(ifc4.grant), 32'd0);
      ifc4.done = 1'b0; ifc4.req = 4'b1111;
      tick();
      chk("t1_ptr3", 32'(ifc4.grant_idx), 32'd3);
      ifc4.req = '0; ifc4.done = 1'b1;
      tick();
      ifc4.done = 1'b0;

      // Rotation with all requesting, done every third cycle
      rst = 1'b1; tick(); rst = 1'b0;
      ifc4.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t2_idx", 32'(ifc4.grant_idx), 32'(k % 4));
         tick();
         ifc4.done = 1'b1;
         tick();
         chk("t2_gap", 32'(ifc4.grant_valid), 32'd0);
         ifc4.done = 1'b0;
      end
      ifc4.req = '0;

      // Hold timeout after exactly 16 granted cycles
      rst = 1'b1; tick(); rst = 1'b0;
      ifc4.req = 4'b0010;
      tick();
      chk("t3_idx", 32'(ifc4.grant_idx), 32'd1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("t3_held", 32'(ifc4.grant_valid), 32'd1);
         chk("t3_no_to", 32'(ifc4.timeout), 32'd0);
      end
      tick();
      chk("t3_timeout", 32'(ifc4.timeout), 32'd1);
      chk("t3_grant0", 32'(ifc4.grant), 32'd0);
      ifc4.req = 4'b1111;
      tick();
      chk("t3_to_pulse", 32'(ifc4.timeout), 32'd0);
      chk("t3_ptr2", 32'(ifc4.grant_idx), 32'd2);
      ifc4.req = '0; ifc4.done = 1'b1;
      tick();
      ifc4.done = 1'b0;

      // done coinciding with the last allowed hold cycle; then done while idle
      rst = 1'b1; tick(); rst = 1'b0;
      ifc4.req = 4'b0001;
      tick();
      ifc4.req = '0;
      for (int i = 1; i < 16; i++) tick();
      ifc4.done = 1'b1;
      tick();
      chk("t4_no_timeout", 32'(ifc4.timeout), 32'd0);
      chk("t4_released", 32'(ifc4.grant_valid), 32'd0);
      tick();
      chk("t4_idle_done", 32'(ifc4.grant_valid), 32'd0);
      ifc4.done = 1'b0; ifc4.req = 4'b1111;
      tick();
      chk("t4_ptr1", 32'(ifc4.grant_idx), 32'd1);
      ifc4.req = '0; ifc4.done = 1'b1;
      tick();
      ifc4.done = 1'b0;

      // Reset in the middle of a grant
      ifc4.req = 4'b1000;
      tick(); tick();
      chk("t5_idx3", 32'(ifc4.grant_idx), 32'd3);
      rst = 1'b1; ifc4.req = '0;
      tick();
      rst = 1'b0;
      chk("t5_grant0", 32'(ifc4.grant), 32'd0);
      chk("t5_idx0", 32'(ifc4.grant_idx), 32'd0);
      ifc4.req = 4'b1001;
      tick();
      chk("t5_regrant", 32'(ifc4.grant_idx), 32'd0);
      ifc4.req = '0; ifc4.done = 1'b1;
      tick();
      ifc4.done = 1'b0;

      // N_REQ=3: owner 2 releases, pointer wraps to 0, never to index 3
      ifc3.req = 3'b100;
      tick();
      chk("t6_idx2", 32'(ifc3.grant_idx), 32'd2);
      ifc3.req = '0; ifc3.done = 1'b1;
      tick();
      ifc3.done = 1'b0; ifc3.req = 3'b111;
      tick();
      chk("t6_wrap", 32'(ifc3.grant_idx), 32'd0);
      ifc3.req = '0; ifc3.done = 1'b1;
      tick();
      ifc3.done = 1'b0;

      // Randomised traffic on both instances against the model
      for (int i = 0; i < 800; i++) begin
         ifc4.req  = 4'($urandom);
         ifc3.req  = 3'($urandom);
         ifc4.done = ($urandom_range(0, 5) == 0);
         ifc3.done = ($urandom_range(0, 3) == 0);
         rst       = ($urandom_range(0, 149) == 0);
         tick();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
